// File: rtl/alu_issue.sv
// ALU issue stage: decodes a MIPS instruction into ALU operands, operation and
// write-back controls, and holds the result in a single handshaked output register.
module alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_op,
    output logic [4:0]  dst_reg,
    output logic        reg_write,
    output logic        is_movz,
    output logic        illegal
);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_OR   = 5'b00010;
    localparam logic [4:0] OP_LUI  = 5'b00011;
    localparam logic [4:0] OP_SLL  = 5'b00100;
    localparam logic [4:0] OP_SRL  = 5'b00101;
    localparam logic [4:0] OP_AND  = 5'b00110;
    localparam logic [4:0] OP_XOR  = 5'b00111;
    localparam logic [4:0] OP_MOVZ = 5'b01000;
    localparam logic [4:0] OP_NOR  = 5'b01001;
    localparam logic [4:0] OP_SRA  = 5'b01010;
    localparam logic [4:0] OP_SLT  = 5'b01011;
    localparam logic [4:0] OP_SLTU = 5'b01100;
    localparam logic [4:0] OP_SEB  = 5'b01101;

    localparam logic [5:0] OPC_SPECIAL  = 6'h00;
    localparam logic [5:0] OPC_ADDI     = 6'h08;
    localparam logic [5:0] OPC_ADDIU    = 6'h09;
    localparam logic [5:0] OPC_SLTI     = 6'h0A;
    localparam logic [5:0] OPC_SLTIU    = 6'h0B;
    localparam logic [5:0] OPC_ANDI     = 6'h0C;
    localparam logic [5:0] OPC_ORI      = 6'h0D;
    localparam logic [5:0] OPC_XORI     = 6'h0E;
    localparam logic [5:0] OPC_LUI      = 6'h0F;
    localparam logic [5:0] OPC_SPECIAL3 = 6'h1F;
    localparam logic [5:0] OPC_LW       = 6'h23;
    localparam logic [5:0] OPC_SW       = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_MOVZ = 6'h0A;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;
    localparam logic [5:0] FN_SEB  = 6'h20;
    localparam logic [4:0] SA_SEB  = 5'h10;

    logic [5:0]  opcode;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic        unused_rs_field;

    assign opcode   = instr[31:26];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign imm      = instr[15:0];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'b0, imm};

    // The rs operand arrives already forwarded, so the rs field itself is not needed.
    assign unused_rs_field = ^instr[25:21];

    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic [4:0]  dec_op;
    logic [4:0]  dec_dst;
    logic        dec_rw;
    logic        dec_movz;
    logic        dec_ill;

    always_comb begin
        dec_a    = '0;
        dec_b    = '0;
        dec_op   = OP_ADD;
        dec_dst  = '0;
        dec_rw   = 1'b0;
        dec_movz = 1'b0;
        dec_ill  = 1'b0;

        case (opcode)
            OPC_SPECIAL: begin
                dec_a   = rs_data;
                dec_b   = rt_data;
                dec_dst = rd;
                dec_rw  = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: dec_op = OP_ADD;
                    FN_SUB, FN_SUBU: dec_op = OP_SUB;
                    FN_OR:           dec_op = OP_OR;
                    FN_AND:          dec_op = OP_AND;
                    FN_XOR:          dec_op = OP_XOR;
                    FN_NOR:          dec_op = OP_NOR;
                    FN_SLT:          dec_op = OP_SLT;
                    FN_SLTU:         dec_op = OP_SLTU;
                    FN_SLL: begin
                        dec_op = OP_SLL;
                        dec_a  = {27'b0, shamt};
                    end
                    FN_SRL: begin
                        dec_op = OP_SRL;
                        dec_a  = {27'b0, shamt};
                    end
                    FN_SRA: begin
                        dec_op = OP_SRA;
                        dec_a  = {27'b0, shamt};
                    end
                    FN_MOVZ: begin
                        dec_op   = OP_MOVZ;
                        dec_movz = 1'b1;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            OPC_ADDI, OPC_ADDIU, OPC_LW: begin
                dec_op  = OP_ADD;
                dec_a   = rs_data;
                dec_b   = imm_sext;
                dec_dst = rt;
                dec_rw  = 1'b1;
            end
            OPC_SW: begin
                dec_op  = OP_ADD;
                dec_a   = rs_data;
                dec_b   = imm_sext;
                dec_dst = rt;
                dec_rw  = 1'b0;
            end
            OPC_SLTI, OPC_SLTIU: begin
                dec_op  = (opcode == OPC_SLTI) ? OP_SLT : OP_SLTU;
                dec_a   = rs_data;
                dec_b   = imm_sext;
                dec_dst = rt;
                dec_rw  = 1'b1;
            end
            OPC_ANDI, OPC_ORI, OPC_XORI, OPC_LUI: begin
                case (opcode)
                    OPC_ANDI: dec_op = OP_AND;
                    OPC_ORI:  dec_op = OP_OR;
                    OPC_XORI: dec_op = OP_XOR;
                    default:  dec_op = OP_LUI;
                endcase
                dec_a   = rs_data;
                dec_b   = imm_zext;
                dec_dst = rt;
                dec_rw  = 1'b1;
            end
            OPC_SPECIAL3: begin
                if (funct == FN_SEB && shamt == SA_SEB) begin
                    dec_op  = OP_SEB;
                    dec_b   = rt_data;
                    dec_dst = rd;
                    dec_rw  = 1'b1;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            default: dec_ill = 1'b1;
        endcase

        // Unsupported encodings travel down the pipe as an all-zero bubble.
        if (dec_ill) begin
            dec_a    = '0;
            dec_b    = '0;
            dec_op   = OP_ADD;
            dec_dst  = '0;
            dec_rw   = 1'b0;
            dec_movz = 1'b0;
        end

        if (dec_dst == 5'd0) begin
            dec_rw = 1'b0;
        end
    end

    logic accept;

    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Flush wins over everything; otherwise a new entry replaces a consumed one with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            dst_reg   <= '0;
            reg_write <= 1'b0;
            is_movz   <= 1'b0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            alu_a     <= dec_a;
            alu_b     <= dec_b;
            alu_op    <= dec_op;
            dst_reg   <= dec_dst;
            reg_write <= dec_rw;
            is_movz   <= dec_movz;
            illegal   <= dec_ill;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
